// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared helpers for the single-clock FIFO family: address-width and
//   power-of-two helpers, pointer/count typedefs for the default geometry,
//   and the read-mode enum.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_ADDR_W = $clog2(DEF_DEPTH);

    // Address bits needed to index 'depth' entries (at least 1).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // One extra MSB on pointers distinguishes full from empty.
    typedef logic [DEF_ADDR_W:0] ptr_t;
    typedef logic [DEF_ADDR_W:0] count_t;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//   DEPTH x DATA_WIDTH register array with one synchronous write port and
//   one asynchronous (combinational) read port. Contents are not reset.
// Ports
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr
// ---------------------------------------------------------------------------
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock parametrised FIFO with watermarks, fill count, sticky
//   over/underflow flags, synchronous flush and selectable read mode
//   (registered read or first-word-fall-through).
// Ports
//   clk            in   clock, all state on posedge
//   rst            in   asynchronous active-high reset
//   flush          in   synchronous clear of pointers/count (not sticky flags, not rdata)
//   wdata          in   write data
//   winc           in   write request
//   wfull          out  count == DEPTH
//   walmost_full   out  count >= AF_LEVEL
//   rinc           in   read request
//   rdata          out  read data (registered or fall-through, per FWFT)
//   rempty         out  count == 0
//   ralmost_empty  out  count <= AE_LEVEL
//   count          out  occupancy 0..DEPTH
//   overflow       out  sticky: write attempted while full
//   underflow      out  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = 14,
    parameter int unsigned AE_LEVEL   = 2,
    parameter int unsigned FWFT       = 0,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  winc,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic                  underflow
);

    // ---- Elaboration-time parameter checks ----
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (!(AE_LEVEL > 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL < DEPTH)) begin : g_bad_levels
        $error("sync_fifo_param: need 0 < AE_LEVEL < AF_LEVEL < DEPTH");
    end
    if (FWFT > 1) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    localparam fifo_mode_e       Mode    = (FWFT == 1) ? FIFO_FWFT : FIFO_STD;
    localparam logic [ADDR_W:0]  One     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]  FullCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  AfCnt   = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]  AeCnt   = (ADDR_W + 1)'(AE_LEVEL);

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            wfull_q, wfull_d;
    logic            walmost_full_q, walmost_full_d;
    logic            rempty_q, rempty_d;
    logic            ralmost_empty_q, ralmost_empty_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Flush wins over both requests; error flags only see non-flushed cycles.
    assign wr_en = winc && !wfull_q  && !flush;
    assign rd_en = rinc && !rempty_q && !flush;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  | (winc && wfull_q  && !flush);
        underflow_d = underflow_q | (rinc && rempty_q && !flush);

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + One;
            end
            if (rd_en) begin
                rptr_d = rptr_q + One;
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + One;
            end else if (rd_en && !wr_en) begin
                count_d = count_q - One;
            end
        end

        // Flags come from the next count so they track the op on its own edge.
        wfull_d         = (count_d == FullCnt);
        walmost_full_d  = (count_d >= AfCnt);
        rempty_d        = (count_d == '0);
        ralmost_empty_d = (count_d <= AeCnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            wfull_q         <= 1'b0;
            walmost_full_q  <= 1'b0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            wfull_q         <= wfull_d;
            walmost_full_q  <= walmost_full_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (rptr_q[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    if (Mode == FIFO_FWFT) begin : g_fwft
        // Shadow of the head so rdata stays at the last head (never X) while empty.
        logic [DATA_WIDTH-1:0] head_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                head_q <= '0;
            end else if (!rempty_q) begin
                head_q <= mem_rdata;
            end
        end

        assign rdata = rempty_q ? head_q : mem_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (rd_en) begin
                rdata_q <= mem_rdata;
            end
        end

        assign rdata = rdata_q;
    end

    assign wfull         = wfull_q;
    assign walmost_full  = walmost_full_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 14;
    localparam int unsigned AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    // Standard-read instance
    logic          flush = 1'b0, winc = 1'b0, rinc = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
    logic [DW-1:0] rdata;
    count_t        count;

    // FWFT instance
    logic          f_flush = 1'b0, f_winc = 1'b0, f_rinc = 1'b0;
    logic [DW-1:0] f_wdata = '0;
    logic          f_wfull, f_walmost_full, f_rempty, f_ralmost_empty, f_overflow, f_underflow;
    logic [DW-1:0] f_rdata;
    count_t        f_count;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (0)
    ) u_std (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .wdata         (wdata),
        .winc          (winc),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .rinc          (rinc),
        .rdata         (rdata),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    sync_fifo_param #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (1)
    ) u_fwft (
        .clk           (clk),
        .rst           (rst),
        .flush         (f_flush),
        .wdata         (f_wdata),
        .winc          (f_winc),
        .wfull         (f_wfull),
        .walmost_full  (f_walmost_full),
        .rinc          (f_rinc),
        .rdata         (f_rdata),
        .rempty        (f_rempty),
        .ralmost_empty (f_ralmost_empty),
        .count         (f_count),
        .overflow      (f_overflow),
        .underflow     (f_underflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the standard instance
    int            mcount = 0;
    bit            movf   = 1'b0;
    bit            mudf   = 1'b0;
    logic [DW-1:0] mrdata = '0;
    logic [DW-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count",         32'(count),         32'(mcount));
        chk("wfull",         32'(wfull),         32'(mcount == DEPTH));
        chk("walmost_full",  32'(walmost_full),  32'(mcount >= AF));
        chk("rempty",        32'(rempty),        32'(mcount == 0));
        chk("ralmost_empty", 32'(ralmost_empty), 32'(mcount <= AE));
        chk("overflow",      32'(overflow),      32'(movf));
        chk("underflow",     32'(underflow),     32'(mudf));
        chk("rdata",         32'(rdata),         32'(mrdata));
    endtask

    // One clock of stimulus on the standard instance with model update and check.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        bit acc_w, acc_r;
        winc  = w;
        wdata = d;
        rinc  = r;
        flush = f;
        acc_r = r && !f && (mcount != 0);
        acc_w = w && !f && (mcount != DEPTH);
        if (!f && w && mcount == DEPTH) movf = 1'b1;
        if (!f && r && mcount == 0)     mudf = 1'b1;
        if (acc_r) mrdata = sb.pop_front();
        if (acc_w) sb.push_back(d);
        if (f) begin
            sb.delete();
            mcount = 0;
        end else begin
            mcount = mcount + int'(acc_w) - int'(acc_r);
        end
        @(posedge clk);
        #1;
        winc  = 1'b0;
        rinc  = 1'b0;
        flush = 1'b0;
        check_state();
    endtask

    initial begin
        // ---- Reset ----
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
        chk("fwft_reset_rdata",  32'(f_rdata),  32'h0);
        chk("fwft_reset_rempty", 32'(f_rempty), 32'h1);

        // ---- FWFT: data falls through the cycle after the write ----
        f_winc = 1'b1; f_wdata = 8'hA5;
        @(posedge clk); #1;
        f_wdata = 8'h5A;
        chk("fwft_rdata_after_wr", 32'(f_rdata),  32'hA5);
        chk("fwft_rempty_after_wr", 32'(f_rempty), 32'h0);
        @(posedge clk); #1;
        f_winc = 1'b0;
        chk("fwft_head_held", 32'(f_rdata), 32'hA5);
        chk("fwft_count2",    32'(f_count), 32'h2);
        f_rinc = 1'b1;
        @(posedge clk); #1;
        chk("fwft_pop1", 32'(f_rdata), 32'h5A);
        @(posedge clk); #1;
        f_rinc = 1'b0;
        chk("fwft_empty",      32'(f_rempty), 32'h1);
        chk("fwft_stale_head", 32'(f_rdata),  32'h5A);
        chk("fwft_no_udf",     32'(f_underflow), 32'h0);

        // ---- Standard mode: 0xA5 visible the cycle after rinc ----
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // ---- Fill 0x00..0x0F, then overflow attempt ----
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);

        // ---- Drain: data intact and in order ----
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);           // underflow
        cycle(1'b0, 8'h00, 1'b0, 1'b1);           // flush keeps sticky flags and rdata

        // ---- Empty + both: write wins ----
        cycle(1'b1, 8'h33, 1'b1, 1'b0);

        // ---- count=5 with both: count holds ----
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h50 + i), 1'b1, 1'b0);

        // ---- Full + both: read wins, count 15 ----
        for (int i = 0; i < 11; i++) cycle(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);

        // ---- Wrap: steady at count ~8 for 40 cycles ----
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // ---- Flush at count=9 with winc: no write happens ----
        for (int i = 0; i < 9; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b1);
        cycle(1'b1, 8'h7E, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);           // must return 0x7E, not 0xC0 or 0xFF

        // ---- Async reset mid-traffic ----
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        winc  = 1'b1;
        wdata = 8'h22;
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        mcount = 0;
        movf   = 1'b0;
        mudf   = 1'b0;
        mrdata = '0;
        check_state();
        @(posedge clk); #1;
        winc = 1'b0;
        rst  = 1'b0;
        check_state();

        // ---- Underflow set via empty + both after reset ----
        cycle(1'b1, 8'h44, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
